ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage RISC-V core: consumes the operands and control registered by the ID/EX pipeline register and produces the write-back value, memory address and store data for the EX/MEM register. ALU, shift, compare, link and RV32M multiply complete in the same cycle. DIV/DIVU/REM/REMU use an iterative radix-2 divider that holds the pipeline with a stall request.

## Interface
Parameters:
- DIV_W, 32, operand/result width of the divider; must equal the register width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low (rst=0 resets).
- ex_alusel  in  `AluSelBus  result class from ID/EX.
- ex_aluop  in  `AluOpBus  operation from ID/EX.
- ex_opv1, ex_opv2  in  `RegBus  source operands.
- ex_waddr  in  `RegAddrBus  destination register.
- ex_we  in  1  register write enable.
- ex_link_addr  in  `InstAddrBus  pc+4 for JAL/JALR.
- ex_mem_offset  in  `RegBus  sign-extended load/store offset.
- hold  in  1  EX/MEM will not capture this cycle (stall from a later stage).
- flush  in  1  kill the instruction in EX.
- wd_o  out  `RegAddrBus  destination to EX/MEM.
- wreg_o  out  1  write enable to EX/MEM.
- wdata_o  out  `RegBus  result.
- aluop_o  out  `AluOpBus  op forwarded to MEM.
- mem_addr_o  out  `RegBus  ex_opv1 + ex_mem_offset.
- mem_data_o  out  `RegBus  store data (= ex_opv2).
- stall_req  out  1  EX needs more cycles; ID/EX and earlier stages hold.

## Operation
- Outputs are combinational from the inputs and the divider state.
- While rst=0, all outputs are 0. The divider FSM goes to IDLE and its internal registers are cleared.
- Result by alusel:
  - LOGIC: and/or/xor.
  - SHIFT: sll/srl/sra by opv2[4:0].
  - ARITH: add/sub/slt/sltu.
  - JUMP: wdata = ex_link_addr.
  - LOAD_STORE: wdata = 0; only mem_addr/mem_data are meaningful.
  - MUL: mul/mulh/mulhsu/mulhu, 64-bit product; low or high word selected.
  - DIV: divider result.
- Address addition wraps modulo 2^32.
- Divider FSM states:
  - IDLE → BUSY when the op is DIV class, divisor ≠ 0, no overflow case, and flush=0. Latch operands as magnitudes plus sign flags.
  - IDLE → DONE when divisor = 0 or the overflow case holds.
  - BUSY runs 32 iterations on a 5-bit counter, then → DONE.
  - DONE → IDLE when hold=0; stays in DONE while hold=1, keeping the result stable.
  - Any state → IDLE on flush=1; a flush in IDLE prevents the start.
- stall_req = 1 when any of these hold:
  - the state is IDLE with a DIV-class op (and flush=0);
  - the state is BUSY;
  - never in DONE.
- Signed fixup (DIV/REM):
  - quotient is negated if the operand signs differ;
  - remainder takes the dividend's sign.
- Boundary results, per RISC-V:
  - divide by 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- wreg_o = ex_we except during flush, when wreg_o = 0.

## Timing
- Non-divide ops: 0-cycle latency; the result is valid in the same cycle the ID/EX register presents the op.
- Normal divide presented in cycle 0:
  - stall_req high in cycles 0–32;
  - DONE in cycle 33, with wdata valid and stall_req low;
  - EX/MEM captures at the end of cycle 33 (if hold=0).
- Special-case divide: stall_req high in cycle 0 only; result valid in cycle 1.
- Back-to-back divides: the second starts from IDLE in the cycle after DONE, with no extra bubble.
- Reset mid-divide: the next cycle is IDLE with stall_req=0.

## Structure
- Operation and class encodings (`EXE_RES_*`, `EXE_*_OP`, including new MUL/DIV ops) live in defines.v. No local literals.
- One sub-module, div_unit: the radix-2 restoring divider FSM with start/signed/flush/ack inputs and done/quotient/remainder outputs.
- ex_stage contains the ALU muxing, the multiplier and the stall logic.

## Test plan
- ARITH ADD opv1=0x7FFFFFFF, opv2=1 → wdata=0x80000000 same cycle, stall_req=0.
- DIVU 100/7 → stall_req for 33 cycles; cycle 33 wdata=14. REMU → 2.
- DIV 0x80000000/0xFFFFFFFF → wdata=0x80000000 after a 1-cycle stall. REM → 0. DIVU x/0 → 0xFFFFFFFF.
- DIV −7/2 → quotient 0xFFFFFFFD (−3); REM → 0xFFFFFFFF (−1).
- DIV in flight, flush at cycle 10 → IDLE next cycle, stall_req=0, wreg_o=0. rst=0 at cycle 5 gives the same result.
- DONE with hold=1 for 3 cycles → wdata stable and stall_req=0 throughout; the op does not restart. Then hold=0 → IDLE.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Widths, operation/class encodings and divider state shared by the execute stage.
package ex_stage_pkg;

    localparam int unsigned REG_W       = 32;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned SHAMT_W     = 5;
    localparam int unsigned DWORD_W     = 2 * REG_W;

    typedef logic [REG_W-1:0] reg_t;

    typedef enum logic [2:0] {
        EXE_RES_NOP,
        EXE_RES_LOGIC,
        EXE_RES_SHIFT,
        EXE_RES_ARITH,
        EXE_RES_JUMP,
        EXE_RES_LOAD_STORE,
        EXE_RES_MUL,
        EXE_RES_DIV
    } alusel_e;

    typedef enum logic [7:0] {
        EXE_NOP_OP = 8'h00,
        EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP,
        EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
        EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP, EXE_SLTU_OP,
        EXE_JAL_OP, EXE_JALR_OP,
        EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP,
        EXE_SB_OP, EXE_SH_OP, EXE_SW_OP,
        EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP,
        EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP
    } aluop_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

    // Sign- or zero-extend an operand to the double width used by the multiplier.
    function automatic logic [DWORD_W-1:0] mul_ext(input reg_t v, input logic is_signed);
        return {{REG_W{is_signed & v[REG_W-1]}}, v};
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operands and control into the execute stage, EX/MEM payload and stall back out.
interface ex_stage_if;
    import ex_stage_pkg::*;

    alusel_e                  ex_alusel;
    aluop_e                   ex_aluop;
    reg_t                     ex_opv1;
    reg_t                     ex_opv2;
    logic [REG_ADDR_W-1:0]    ex_waddr;
    logic                     ex_we;
    logic [INST_ADDR_W-1:0]   ex_link_addr;
    reg_t                     ex_mem_offset;
    logic                     hold;
    logic                     flush;

    logic [REG_ADDR_W-1:0]    wd_o;
    logic                     wreg_o;
    reg_t                     wdata_o;
    aluop_e                   aluop_o;
    reg_t                     mem_addr_o;
    reg_t                     mem_data_o;
    logic                     stall_req;

    modport master (
        output ex_alusel, ex_aluop, ex_opv1, ex_opv2, ex_waddr, ex_we,
               ex_link_addr, ex_mem_offset, hold, flush,
        input  wd_o, wreg_o, wdata_o, aluop_o, mem_addr_o, mem_data_o, stall_req
    );

    modport slave (
        input  ex_alusel, ex_aluop, ex_opv1, ex_opv2, ex_waddr, ex_we,
               ex_link_addr, ex_mem_offset, hold, flush,
        output wd_o, wreg_o, wdata_o, aluop_o, mem_addr_o, mem_data_o, stall_req
    );

endinterface

// File: rtl/ex_stage_div_unit.sv
// Radix-2 restoring divider: one quotient bit per BUSY cycle, RISC-V divide-by-zero/overflow shortcuts.
module ex_stage_div_unit
    import ex_stage_pkg::*;
#(
    parameter int unsigned DIV_W = REG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             flush_i,
    input  logic             ack_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [DIV_W-1:0] quotient_o,
    output logic [DIV_W-1:0] remainder_o
);

    localparam int unsigned      CNT_W    = $clog2(DIV_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

    div_state_e       state_q;
    logic [DIV_W-1:0] quo_q, rem_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q, neg_rem_q;

    logic             dvd_neg, dvs_neg, overflow, ge;
    logic [DIV_W-1:0] dvd_mag, dvs_mag, int_min;
    logic [DIV_W:0]   trial, diff;

    assign int_min  = {1'b1, {(DIV_W-1){1'b0}}};
    assign dvd_neg  = signed_i && dividend_i[DIV_W-1];
    assign dvs_neg  = signed_i && divisor_i[DIV_W-1];
    assign dvd_mag  = dvd_neg ? -dividend_i : dividend_i;
    assign dvs_mag  = dvs_neg ? -divisor_i : divisor_i;
    assign overflow = signed_i && (dividend_i == int_min) && (divisor_i == '1);

    // Partial remainder never reaches twice the divisor, so the borrow bit alone decides the quotient bit.
    assign trial = {rem_q, quo_q[DIV_W-1]};
    assign diff  = trial - {1'b0, dvs_q};
    assign ge    = !diff[DIV_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= DIV_IDLE;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i && !flush_i) begin
                        cnt_q     <= '0;
                        neg_quo_q <= 1'b0;
                        neg_rem_q <= 1'b0;
                        if (divisor_i == '0) begin
                            quo_q   <= '1;
                            rem_q   <= dividend_i;
                            state_q <= DIV_DONE;
                        end else if (overflow) begin
                            quo_q   <= int_min;
                            rem_q   <= '0;
                            state_q <= DIV_DONE;
                        end else begin
                            quo_q     <= dvd_mag;
                            rem_q     <= '0;
                            dvs_q     <= dvs_mag;
                            neg_quo_q <= dvd_neg ^ dvs_neg;
                            neg_rem_q <= dvd_neg;
                            state_q   <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (flush_i) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        quo_q <= {quo_q[DIV_W-2:0], ge};
                        rem_q <= ge ? diff[DIV_W-1:0] : trial[DIV_W-1:0];
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    if (flush_i || ack_i) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: state_q <= DIV_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q == DIV_BUSY);
    assign done_o      = (state_q == DIV_DONE);
    assign quotient_o  = neg_quo_q ? -quo_q : quo_q;
    assign remainder_o = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/shift/compare/link/multiply, iterative divide with stall request.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DIV_W = REG_W
) (
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave ex
);

    logic               div_op, div_signed, div_busy, div_done;
    logic [DIV_W-1:0]   div_quo, div_rem;
    logic [DWORD_W-1:0] product;
    logic [SHAMT_W-1:0] shamt;
    reg_t               result;

    assign div_op     = (ex.ex_alusel == EXE_RES_DIV);
    assign div_signed = (ex.ex_aluop == EXE_DIV_OP) || (ex.ex_aluop == EXE_REM_OP);
    assign shamt      = ex.ex_opv2[SHAMT_W-1:0];

    ex_stage_div_unit #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .start_i     (div_op),
        .signed_i    (div_signed),
        .flush_i     (ex.flush),
        .ack_i       (!ex.hold),
        .dividend_i  (ex.ex_opv1),
        .divisor_i   (ex.ex_opv2),
        .busy_o      (div_busy),
        .done_o      (div_done),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    // MULH: signed x signed, MULHSU: signed x unsigned, MUL/MULHU: unsigned halves of one product.
    assign product = mul_ext(ex.ex_opv1, ex.ex_aluop inside {EXE_MULH_OP, EXE_MULHSU_OP})
                   * mul_ext(ex.ex_opv2, ex.ex_aluop == EXE_MULH_OP);

    always_comb begin
        result = '0;
        case (ex.ex_alusel)
            EXE_RES_LOGIC: begin
                case (ex.ex_aluop)
                    EXE_AND_OP: result = ex.ex_opv1 & ex.ex_opv2;
                    EXE_OR_OP:  result = ex.ex_opv1 | ex.ex_opv2;
                    EXE_XOR_OP: result = ex.ex_opv1 ^ ex.ex_opv2;
                    default:    result = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (ex.ex_aluop)
                    EXE_SLL_OP: result = ex.ex_opv1 << shamt;
                    EXE_SRL_OP: result = ex.ex_opv1 >> shamt;
                    EXE_SRA_OP: result = $unsigned($signed(ex.ex_opv1) >>> shamt);
                    default:    result = '0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (ex.ex_aluop)
                    EXE_ADD_OP:  result = ex.ex_opv1 + ex.ex_opv2;
                    EXE_SUB_OP:  result = ex.ex_opv1 - ex.ex_opv2;
                    EXE_SLT_OP:  result = REG_W'($signed(ex.ex_opv1) < $signed(ex.ex_opv2));
                    EXE_SLTU_OP: result = REG_W'(ex.ex_opv1 < ex.ex_opv2);
                    default:     result = '0;
                endcase
            end
            EXE_RES_JUMP: result = REG_W'(ex.ex_link_addr);
            EXE_RES_MUL: begin
                result = (ex.ex_aluop == EXE_MUL_OP) ? product[REG_W-1:0]
                                                     : product[DWORD_W-1:REG_W];
            end
            EXE_RES_DIV: begin
                if (div_done) begin
                    result = REG_W'((ex.ex_aluop inside {EXE_REM_OP, EXE_REMU_OP}) ? div_rem : div_quo);
                end
            end
            default: result = '0;
        endcase
    end

    always_comb begin
        ex.wd_o       = '0;
        ex.wreg_o     = 1'b0;
        ex.wdata_o    = '0;
        ex.aluop_o    = EXE_NOP_OP;
        ex.mem_addr_o = '0;
        ex.mem_data_o = '0;
        ex.stall_req  = 1'b0;
        if (rst) begin
            ex.wd_o       = ex.ex_waddr;
            ex.wreg_o     = ex.ex_we && !ex.flush;
            ex.wdata_o    = result;
            ex.aluop_o    = ex.ex_aluop;
            ex.mem_addr_o = ex.ex_opv1 + ex.ex_mem_offset;
            ex.mem_data_o = ex.ex_opv2;
            // An idle divider facing a divide holds the front end for its start cycle.
            ex.stall_req  = div_busy || (div_op && !ex.flush && !div_busy && !div_done);
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage plus directed flush, reset and hold cases around the divider.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int MAX_WAIT = 40;

    typedef struct {
        logic [31:0] wdata;
        logic [31:0] mem_addr;
        int          stalls;
    } exp_t;

    logic        clk;
    logic        rst;
    ex_stage_if  bus ();

    ex_stage #(.DIV_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus.slave)
    );

    exp_t        sb_q[$];
    string       tag_q[$];
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          stall_cnt = 0;
    logic        op_active = 1'b0;
    logic [31:0] mem_off   = 32'h10;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input alusel_e sel, input aluop_e op, input logic [31:0] a, input logic [31:0] b);
        bus.ex_alusel     = sel;
        bus.ex_aluop      = op;
        bus.ex_opv1       = a;
        bus.ex_opv2       = b;
        bus.ex_we         = (sel != EXE_RES_NOP);
        bus.ex_mem_offset = mem_off;
    endtask

    task automatic bubble();
        drive(EXE_RES_NOP, EXE_NOP_OP, 32'h0, 32'h0);
        op_active = 1'b0;
    endtask

    // Waits for stall_req to drop, counting stalled cycles; a blown budget is a failed comparison.
    task automatic wait_done(input string tag, inout int n);
        bit ok = 1'b0;
        for (int i = 0; i < MAX_WAIT && !ok; i++) begin
            @(negedge clk);
            if (bus.stall_req) n++;
            else ok = 1'b1;
        end
        if (!ok) chk({tag, " timeout"}, 32'(bus.stall_req), 32'd0);
    endtask

    task automatic run_op(input string tag, input alusel_e sel, input aluop_e op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_stalls);
        exp_t e;
        int   n = 0;
        drive(sel, op, a, b);
        e.wdata    = exp;
        e.mem_addr = a + mem_off;
        e.stalls   = exp_stalls;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        op_active = 1'b1;
        wait_done(tag, n);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t  e;
        string t;
        forever begin
            @(negedge clk);
            if (op_active && rst) begin
                if (bus.stall_req) begin
                    stall_cnt++;
                end else if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    t = tag_q.pop_front();
                    chk({t, " wdata"}, bus.wdata_o, e.wdata);
                    chk({t, " addr"}, bus.mem_addr_o, e.mem_addr);
                    chk({t, " stalls"}, 32'(stall_cnt), 32'(e.stalls));
                    stall_cnt = 0;
                end
            end
        end
    end

    initial begin : main
        int n;
        rst              = 1'b0;
        bus.hold         = 1'b0;
        bus.flush        = 1'b0;
        bus.ex_waddr     = 5'd3;
        bus.ex_link_addr = 32'h0000_1004;
        drive(EXE_RES_ARITH, EXE_ADD_OP, 32'h1234, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst wdata", bus.wdata_o, 32'h0);
        chk("rst wreg", 32'(bus.wreg_o), 32'h0);
        chk("rst addr", bus.mem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_op("add_ovf", EXE_RES_ARITH, EXE_ADD_OP,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 0);
        run_op("sub",     EXE_RES_ARITH, EXE_SUB_OP,  32'h5,         32'h7,         32'hFFFF_FFFE, 0);
        run_op("slt",     EXE_RES_ARITH, EXE_SLT_OP,  32'hFFFF_FFFF, 32'h1,         32'h1,         0);
        run_op("sltu",    EXE_RES_ARITH, EXE_SLTU_OP, 32'hFFFF_FFFF, 32'h1,         32'h0,         0);
        run_op("and",     EXE_RES_LOGIC, EXE_AND_OP,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 0);
        run_op("or",      EXE_RES_LOGIC, EXE_OR_OP,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 0);
        run_op("xor",     EXE_RES_LOGIC, EXE_XOR_OP,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 0);
        run_op("sll",     EXE_RES_SHIFT, EXE_SLL_OP,  32'h1,         32'h3F,        32'h8000_0000, 0);
        run_op("srl",     EXE_RES_SHIFT, EXE_SRL_OP,  32'h8000_0000, 32'h4,         32'h0800_0000, 0);
        run_op("sra",     EXE_RES_SHIFT, EXE_SRA_OP,  32'h8000_0000, 32'h4,         32'hF800_0000, 0);
        run_op("jal",     EXE_RES_JUMP,  EXE_JAL_OP,  32'h0,         32'h0,         32'h0000_1004, 0);
        mem_off = 32'h20;
        run_op("sw_wrap", EXE_RES_LOAD_STORE, EXE_SW_OP, 32'hFFFF_FFF0, 32'h1234,  32'h0,         0);
        mem_off = 32'h10;
        run_op("mul",     EXE_RES_MUL, EXE_MUL_OP,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         0);
        run_op("mulh",    EXE_RES_MUL, EXE_MULH_OP,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        run_op("mulhu",   EXE_RES_MUL, EXE_MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("mulhsu",  EXE_RES_MUL, EXE_MULHSU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("divu",    EXE_RES_DIV, EXE_DIVU_OP,   32'd100,       32'd7,         32'd14,        33);
        run_op("remu",    EXE_RES_DIV, EXE_REMU_OP,   32'd100,       32'd7,         32'd2,         33);
        run_op("div_ovf", EXE_RES_DIV, EXE_DIV_OP,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", EXE_RES_DIV, EXE_REM_OP,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
        run_op("divu0",   EXE_RES_DIV, EXE_DIVU_OP,   32'h1234,      32'h0,         32'hFFFF_FFFF, 1);
        run_op("remu0",   EXE_RES_DIV, EXE_REMU_OP,   32'h1234,      32'h0,         32'h1234,      1);
        run_op("div0",    EXE_RES_DIV, EXE_DIV_OP,    32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF, 1);
        run_op("rem0",    EXE_RES_DIV, EXE_REM_OP,    32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 1);
        run_op("div_neg", EXE_RES_DIV, EXE_DIV_OP,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33);
        run_op("rem_neg", EXE_RES_DIV, EXE_REM_OP,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33);
        run_op("div_nd",  EXE_RES_DIV, EXE_DIV_OP,    32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_nd",  EXE_RES_DIV, EXE_REM_OP,    32'h7,         32'hFFFF_FFFE, 32'h1,         33);
        run_op("divu_max",EXE_RES_DIV, EXE_DIVU_OP,   32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 33);
        run_op("div_min", EXE_RES_DIV, EXE_DIV_OP,    32'h8000_0000, 32'h2,         32'hC000_0000, 33);
        bubble();
        @(posedge clk);
        #1;

        // Flush in cycle 10 of a divide.
        drive(EXE_RES_DIV, EXE_DIVU_OP, 32'd100, 32'd7);
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.stall_req) n++;
        end
        chk("flush pre stalls", 32'(n), 32'd10);
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush wreg", 32'(bus.wreg_o), 32'h0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bubble();
        @(negedge clk);
        chk("flush next stall", 32'(bus.stall_req), 32'h0);
        @(posedge clk);
        #1;

        // Reset in cycle 5 of a divide.
        drive(EXE_RES_DIV, EXE_DIV_OP, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst stall", 32'(bus.stall_req), 32'h0);
        chk("midrst wreg", 32'(bus.wreg_o), 32'h0);
        chk("midrst addr", bus.mem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bubble();
        @(negedge clk);
        chk("midrst next stall", 32'(bus.stall_req), 32'h0);
        @(posedge clk);
        #1;

        // DONE held for three cycles, then released straight into a new divide.
        bus.hold = 1'b1;
        drive(EXE_RES_DIV, EXE_DIVU_OP, 32'd100, 32'd7);
        n = 0;
        wait_done("hold", n);
        chk("hold stalls", 32'(n), 32'd33);
        for (int k = 0; k < 3; k++) begin
            chk("hold wdata", bus.wdata_o, 32'd14);
            chk("hold stall", 32'(bus.stall_req), 32'h0);
            @(negedge clk);
        end
        chk("hold wdata end", bus.wdata_o, 32'd14);
        bus.hold = 1'b0;
        @(posedge clk);
        #1;
        n = 0;
        wait_done("hold restart", n);
        chk("hold restart stalls", 32'(n), 32'd33);
        chk("hold restart wdata", bus.wdata_o, 32'd14);
        @(posedge clk);
        #1;
        bubble();
        @(posedge clk);
        #1;

        run_op("div_after", EXE_RES_DIV, EXE_DIV_OP, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
        bubble();
        repeat (2) @(posedge clk);
        chk("sb empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
